// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the SPI-mode SD card responder.
package sd_resp_pkg;

    typedef enum logic [3:0] {
        StCmdHunt,
        StCmdRx,
        StRespNcr,
        StRespTx,
        StRdGap,
        StRdToken,
        StRdData,
        StRdCrc,
        StWrTokenWait,
        StWrData,
        StWrCrc,
        StWrDresp,
        StWrBusy
    } state_t;

    localparam logic [5:0] CmdGoIdle     = 6'd0;
    localparam logic [5:0] CmdSendIfCond = 6'd8;
    localparam logic [5:0] CmdReadBlock  = 6'd17;
    localparam logic [5:0] CmdWriteBlock = 6'd24;
    localparam logic [5:0] CmdAppOpCond  = 6'd41;
    localparam logic [5:0] CmdAppCmd     = 6'd55;
    localparam logic [5:0] CmdReadOcr    = 6'd58;

    localparam logic [7:0] TokStart        = 8'hFE;
    localparam logic [7:0] TokDataAccepted = 8'h05;

    localparam logic [7:0] R1Idle    = 8'h01;
    localparam logic [7:0] R1Illegal = 8'h04;
    localparam logic [7:0] R1Address = 8'h20;

    // CCS=1: block addressing, full 2.7-3.6 V window.
    localparam logic [31:0] Ocr = 32'hC0FF_8000;

    function automatic logic is_cmd_start(input logic [7:0] b);
        return b[7:6] == 2'b01;
    endfunction

endpackage

// File: rtl/sd_spi_responder_byte.sv
// SPI mode-0 byte engine: synchronises the master's pins into clk, shifts bytes in on
// spi_clk rise and out on spi_clk fall.
module spi_byte_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       spi_clk,
    input  logic       mosi,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    output logic       miso,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       byte_done,
    output logic       cs_high
);

    logic       cs_meta, cs_sync;
    logic       sck_meta, sck_sync, sck_prev;
    logic       mosi_meta, mosi_sync;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic       sck_rise, sck_fall;

    // A deselect in the same cycle as an edge drops the edge.
    assign sck_rise  = sck_sync & ~sck_prev & ~cs_sync;
    assign sck_fall  = ~sck_sync & sck_prev & ~cs_sync;
    assign cs_high   = cs_sync;
    assign rx_valid  = sck_rise && (bit_cnt == 3'd7);
    assign byte_done = rx_valid;
    assign rx_byte   = {rx_sr, mosi_sync};

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            mosi_meta <= 1'b1;
            mosi_sync <= 1'b1;
        end else begin
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            sck_meta  <= spi_clk;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            rx_sr   <= 7'd0;
            tx_sr   <= 8'hFF;
            miso    <= 1'b1;
        end else if (cs_sync) begin
            bit_cnt <= 3'd0;
            tx_sr   <= 8'hFF;
            miso    <= 1'b1;
        end else begin
            if (sck_rise) begin
                rx_sr   <= {rx_sr[5:0], mosi_sync};
                bit_cnt <= bit_cnt + 3'd1;
            end
            // The load lands between the 8th rise and the following fall.
            if (tx_load) begin
                tx_sr <= tx_byte;
            end else if (sck_fall) begin
                miso  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card model: answers the init sequence plus single-block read and write,
// with block contents held in an external byte-wide memory.
module sd_spi_responder
    import sd_resp_pkg::*;
#(
    parameter int unsigned BLK_W      = 8,
    parameter int unsigned INIT_POLLS = 3,
    parameter int unsigned READ_GAP   = 2,
    parameter int unsigned BUSY_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             spi_clk,
    input  logic             mosi,
    output logic             miso,
    output logic [BLK_W+8:0] mem_addr,
    input  logic [7:0]       mem_rdata,
    output logic [7:0]       mem_wdata,
    output logic             mem_we,
    output logic             card_ready
);

    logic [7:0]  rx_byte;
    logic        rx_valid, byte_done, cs_high;
    logic [7:0]  tx_byte;
    logic        tx_load;

    state_t      state, next_st;
    logic [5:0]  cmd_idx;
    logic [31:0] arg;
    logic [9:0]  cnt;
    logic [39:0] resp;
    logic [2:0]  resp_len;
    logic        app_flag;
    logic [7:0]  acmd_cnt;

    logic [7:0]  idle;
    logic [7:0]  acmd_next;
    logic        in_range;
    logic [39:0] dec_resp;
    logic [2:0]  dec_len;
    state_t      dec_after;
    logic        dec_app, dec_acmd_inc, dec_acmd_clr, dec_ready_set, dec_ready_clr;

    spi_byte_slave u_byte (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .spi_clk   (spi_clk),
        .mosi      (mosi),
        .tx_byte   (tx_byte),
        .tx_load   (tx_load),
        .miso      (miso),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .byte_done (byte_done),
        .cs_high   (cs_high)
    );

    // Command decode; only consumed when the CRC byte of a command arrives.
    always_comb begin
        idle          = {7'd0, ~card_ready};
        acmd_next     = (acmd_cnt == 8'hFF) ? acmd_cnt : acmd_cnt + 8'd1;
        in_range      = ((arg >> BLK_W) == 32'd0);
        dec_resp      = {idle | R1Illegal, 32'hFFFF_FFFF};
        dec_len       = 3'd1;
        dec_after     = StCmdHunt;
        dec_app       = 1'b0;
        dec_acmd_inc  = 1'b0;
        dec_acmd_clr  = 1'b0;
        dec_ready_set = 1'b0;
        dec_ready_clr = 1'b0;
        case (cmd_idx)
            CmdGoIdle: begin
                dec_resp[39:32] = R1Idle;
                dec_ready_clr   = 1'b1;
                dec_acmd_clr    = 1'b1;
            end
            CmdSendIfCond: begin
                dec_resp = {idle, 8'h00, 8'h00, 8'h01, arg[7:0]};
                dec_len  = 3'd5;
            end
            CmdAppCmd: begin
                dec_resp[39:32] = idle;
                dec_app         = 1'b1;
            end
            CmdAppOpCond: begin
                if (app_flag) begin
                    dec_acmd_inc = 1'b1;
                    if (32'(acmd_next) >= INIT_POLLS) begin
                        dec_resp[39:32] = 8'h00;
                        dec_ready_set   = 1'b1;
                    end else begin
                        dec_resp[39:32] = R1Idle;
                    end
                end
            end
            CmdReadOcr: begin
                dec_resp = {idle, Ocr};
                dec_len  = 3'd5;
            end
            CmdReadBlock, CmdWriteBlock: begin
                if (card_ready) begin
                    if (!in_range) begin
                        dec_resp[39:32] = R1Address;
                    end else begin
                        dec_resp[39:32] = 8'h00;
                        if (cmd_idx == CmdWriteBlock) begin
                            dec_after = StWrTokenWait;
                        end else begin
                            dec_after = (READ_GAP == 0) ? StRdToken : StRdGap;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StCmdHunt;
            next_st    <= StCmdHunt;
            cmd_idx    <= 6'd0;
            arg        <= 32'd0;
            cnt        <= 10'd0;
            resp       <= 40'd0;
            resp_len   <= 3'd0;
            app_flag   <= 1'b0;
            acmd_cnt   <= 8'd0;
            card_ready <= 1'b0;
            tx_byte    <= 8'hFF;
            tx_load    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            mem_we     <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            mem_we  <= 1'b0;
            if (cs_high) begin
                state <= StCmdHunt;
            end else if (byte_done) begin
                // Every completed byte reloads the transmitter; idle filler is 0xFF.
                tx_load <= 1'b1;
                tx_byte <= 8'hFF;
                unique case (state)
                    StCmdHunt: begin
                        if (rx_valid && is_cmd_start(rx_byte)) begin
                            cmd_idx <= rx_byte[5:0];
                            cnt     <= 10'd0;
                            state   <= StCmdRx;
                        end
                    end
                    StCmdRx: begin
                        if (cnt == 10'd4) begin
                            resp     <= dec_resp;
                            resp_len <= dec_len;
                            next_st  <= dec_after;
                            app_flag <= dec_app;
                            if (dec_acmd_clr) begin
                                acmd_cnt <= 8'd0;
                            end else if (dec_acmd_inc) begin
                                acmd_cnt <= acmd_next;
                            end
                            if (dec_ready_clr) begin
                                card_ready <= 1'b0;
                            end else if (dec_ready_set) begin
                                card_ready <= 1'b1;
                            end
                            if (dec_after != StCmdHunt) begin
                                mem_addr <= {arg[BLK_W-1:0], 9'd0};
                            end
                            state <= StRespNcr;
                        end else begin
                            arg <= {arg[23:0], rx_byte};
                            cnt <= cnt + 10'd1;
                        end
                    end
                    StRespNcr: begin
                        tx_byte <= resp[39:32];
                        resp    <= {resp[31:0], 8'hFF};
                        cnt     <= {7'd0, resp_len} - 10'd1;
                        state   <= StRespTx;
                    end
                    StRespTx: begin
                        if (cnt != 10'd0) begin
                            tx_byte <= resp[39:32];
                            resp    <= {resp[31:0], 8'hFF};
                            cnt     <= cnt - 10'd1;
                        end else begin
                            cnt   <= 10'd0;
                            state <= next_st;
                            if (next_st == StRdToken) begin
                                tx_byte <= TokStart;
                            end
                        end
                    end
                    StRdGap: begin
                        if (cnt == 10'(READ_GAP - 1)) begin
                            tx_byte <= TokStart;
                            state   <= StRdToken;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    StRdToken: begin
                        tx_byte       <= mem_rdata;
                        mem_addr[8:0] <= 9'd1;
                        cnt           <= 10'd0;
                        state         <= StRdData;
                    end
                    StRdData: begin
                        // The address already points one byte ahead of the byte loaded.
                        if (cnt == 10'd511) begin
                            cnt   <= 10'd0;
                            state <= StRdCrc;
                        end else begin
                            tx_byte <= mem_rdata;
                            cnt     <= cnt + 10'd1;
                            if (mem_addr[8:0] != 9'h1FF) begin
                                mem_addr[8:0] <= mem_addr[8:0] + 9'd1;
                            end
                        end
                    end
                    StRdCrc: begin
                        if (cnt == 10'd0) begin
                            cnt <= 10'd1;
                        end else begin
                            state <= StCmdHunt;
                        end
                    end
                    StWrTokenWait: begin
                        if (rx_byte == TokStart) begin
                            cnt   <= 10'd0;
                            state <= StWrData;
                        end
                    end
                    StWrData: begin
                        mem_we        <= 1'b1;
                        mem_wdata     <= rx_byte;
                        mem_addr[8:0] <= cnt[8:0];
                        if (cnt == 10'd511) begin
                            cnt   <= 10'd0;
                            state <= StWrCrc;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    StWrCrc: begin
                        if (cnt == 10'd0) begin
                            cnt <= 10'd1;
                        end else begin
                            tx_byte <= TokDataAccepted;
                            state   <= StWrDresp;
                        end
                    end
                    StWrDresp: begin
                        if (BUSY_BYTES == 0) begin
                            state <= StCmdHunt;
                        end else begin
                            tx_byte <= 8'h00;
                            cnt     <= 10'd0;
                            state   <= StWrBusy;
                        end
                    end
                    StWrBusy: begin
                        if (cnt == 10'(BUSY_BYTES - 1)) begin
                            state <= StCmdHunt;
                        end else begin
                            tx_byte <= 8'h00;
                            cnt     <= cnt + 10'd1;
                        end
                    end
                    default: state <= StCmdHunt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: a bit-banged SPI master plus a byte memory model.
module tb_sd_spi_responder;

    localparam int BLK_W = 8;
    localparam int AW    = BLK_W + 9;
    localparam int HALF  = 40;

    logic          clk = 1'b0;
    logic          rst, cs, spi_clk, mosi;
    logic          miso, mem_we, card_ready;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata, mem_wdata;

    sd_spi_responder #(
        .BLK_W      (BLK_W),
        .INIT_POLLS (3),
        .READ_GAP   (2),
        .BUSY_BYTES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .spi_clk    (spi_clk),
        .mosi       (mosi),
        .miso       (miso),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .card_ready (card_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1 << AW) - 1];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int            n_cmp = 0;
    int            n_bad = 0;
    int            we_count = 0;
    int            wr_err = 0;
    int            we_start = 0;
    logic [AW-1:0] wr_base = '0;
    logic [7:0]    wr_data = 8'h00;

    // Write monitor: each strobe must hit the next sequential address with the expected data.
    always @(negedge clk) begin
        if (mem_we) begin
            if (mem_addr !== wr_base + AW'(we_count - we_start) || mem_wdata !== wr_data) begin
                wr_err++;
            end
            we_count++;
        end
    end

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        int          n;
        logic [47:0] resp;
        logic        ready;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #HALF;
            spi_clk = 1'b1;
            rx[i] = miso;
            #HALF;
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] a);
        logic [47:0] f;
        logic [7:0]  d;
        f = {2'b01, idx, a, 8'h01};
        for (int k = 0; k < 6; k++) spi_byte(f[47-8*k -: 8], d);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [39:0] rd_pre;
        logic [7:0]  exp_b;
        int          err0;

        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'h00;
        for (int i = 0; i < 512; i++) mem[{8'd5, 9'(i)}] = 8'(i);

        vecs[0]  = '{6'd0,  32'h0000_0000, 2, 48'hFF01_0000_0000, 1'b0};
        vecs[1]  = '{6'd17, 32'h0000_0005, 2, 48'hFF05_0000_0000, 1'b0};
        vecs[2]  = '{6'd8,  32'h0000_01AA, 6, 48'hFF01_0000_01AA, 1'b0};
        vecs[3]  = '{6'd41, 32'h4000_0000, 2, 48'hFF05_0000_0000, 1'b0};
        vecs[4]  = '{6'd55, 32'h0000_0000, 2, 48'hFF01_0000_0000, 1'b0};
        vecs[5]  = '{6'd41, 32'h4000_0000, 2, 48'hFF01_0000_0000, 1'b0};
        vecs[6]  = '{6'd55, 32'h0000_0000, 2, 48'hFF01_0000_0000, 1'b0};
        vecs[7]  = '{6'd41, 32'h4000_0000, 2, 48'hFF01_0000_0000, 1'b0};
        vecs[8]  = '{6'd55, 32'h0000_0000, 2, 48'hFF01_0000_0000, 1'b0};
        vecs[9]  = '{6'd41, 32'h4000_0000, 2, 48'hFF00_0000_0000, 1'b1};
        vecs[10] = '{6'd58, 32'h0000_0000, 6, 48'hFF00_C0FF_8000, 1'b1};
        vecs[11] = '{6'd42, 32'h0000_0000, 2, 48'hFF04_0000_0000, 1'b1};
        vecs[12] = '{6'd17, 32'h0000_0100, 2, 48'hFF20_0000_0000, 1'b1};

        rst = 1'b1;
        cs = 1'b1;
        spi_clk = 1'b0;
        mosi = 1'b1;
        repeat (4) @(negedge clk);
        check("reset miso", 32'(miso), 32'd1);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset card_ready", 32'(card_ready), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cs = 1'b0;
        #80;

        for (int v = 0; v < 13; v++) begin
            send_cmd(vecs[v].cmd, vecs[v].arg);
            for (int b = 0; b < vecs[v].n; b++) begin
                spi_byte(8'hFF, d);
                check($sformatf("vec%0d cmd%0d byte%0d", v, vecs[v].cmd, b), 32'(d),
                      32'(vecs[v].resp[47-8*b -: 8]));
            end
            check($sformatf("vec%0d card_ready", v), 32'(card_ready), 32'(vecs[v].ready));
            spi_byte(8'hFF, d);
            check($sformatf("vec%0d trailing idle", v), 32'(d), 32'hFF);
        end

        // Single-block read of block 5.
        rd_pre = 40'hFF00_FFFF_FE;
        send_cmd(6'd17, 32'd5);
        for (int b = 0; b < 5 + 512 + 2; b++) begin
            if (b < 5) exp_b = rd_pre[39-8*b -: 8];
            else if (b < 517) exp_b = 8'(b - 5);
            else exp_b = 8'hFF;
            spi_byte(8'hFF, d);
            check($sformatf("read byte%0d", b), 32'(d), 32'(exp_b));
        end
        spi_byte(8'hFF, d);
        check("read trailing idle", 32'(d), 32'hFF);

        // Single-block write of block 3 with 0xA5.
        wr_base = AW'({8'd3, 9'd0});
        wr_data = 8'hA5;
        we_start = we_count;
        err0 = wr_err;
        send_cmd(6'd24, 32'd3);
        spi_byte(8'hFF, d);
        check("write ncr", 32'(d), 32'hFF);
        spi_byte(8'hFF, d);
        check("write r1", 32'(d), 32'h00);
        spi_byte(8'hFF, d);
        spi_byte(8'hFE, d);
        for (int i = 0; i < 512; i++) spi_byte(8'hA5, d);
        spi_byte(8'h12, d);
        spi_byte(8'h34, d);
        spi_byte(8'hFF, d);
        check("write data response", 32'(d), 32'h05);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'hFF, d);
            check($sformatf("write busy%0d", i), 32'(d), 32'h00);
        end
        spi_byte(8'hFF, d);
        check("write released", 32'(d), 32'hFF);
        check("write strobe count", 32'(we_count - we_start), 32'd512);
        check("write addr/data errors", 32'(wr_err - err0), 32'd0);

        // Aborted write: deselect after 100 data bytes.
        wr_base = AW'({8'd7, 9'd0});
        wr_data = 8'h3C;
        we_start = we_count;
        err0 = wr_err;
        send_cmd(6'd24, 32'd7);
        spi_byte(8'hFF, d);
        spi_byte(8'hFF, d);
        check("abort r1", 32'(d), 32'h00);
        spi_byte(8'hFF, d);
        spi_byte(8'hFE, d);
        for (int i = 0; i < 100; i++) spi_byte(8'h3C, d);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        mosi = 1'b1;
        spi_clk = 1'b0;
        cs = 1'b0;
        #80;
        check("abort strobe count", 32'(we_count - we_start), 32'd100);
        check("abort addr/data errors", 32'(wr_err - err0), 32'd0);
        send_cmd(6'd0, 32'd0);
        spi_byte(8'hFF, d);
        check("post-abort ncr", 32'(d), 32'hFF);
        spi_byte(8'hFF, d);
        check("post-abort cmd0 r1", 32'(d), 32'h01);
        check("post-abort card_ready", 32'(card_ready), 32'd0);

        // Reset after activity returns registers to their reset values.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("late reset mem_addr", 32'(mem_addr), 32'd0);
        check("late reset mem_wdata", 32'(mem_wdata), 32'd0);
        check("late reset miso", 32'(miso), 32'd1);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
